// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled counting and a multiplexed,
// leading-zero-blanking display scanner feeding a 7-segment decoder.
module bcd_scan_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        lzb,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  digit_sel,
    output logic [15:0] count,
    output logic        carry
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tdiv;
    logic [SW-1:0] sdiv;
    logic [1:0]    idx;
    logic [1:0]    next_idx;
    logic [3:0]    shown;
    logic          tick;
    logic          scan_wrap;
    logic          hi_zero;
    logic          blank;
    logic          inc_c;
    logic          dec_b;
    logic [15:0]   count_inc;
    logic [15:0]   count_dec;
    logic [15:0]   load_clamped;

    assign tick      = en && (tdiv == T_LAST);
    assign scan_wrap = (sdiv == S_LAST);
    assign next_idx  = idx + 2'd1;
    assign {a, b, c, d} = shown;

    // Ripple BCD increment/decrement: a digit only changes while the
    // carry/borrow from the lower digits is still pending.
    always_comb begin
        count_inc = count;
        count_dec = count;
        inc_c = 1'b1;
        dec_b = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (inc_c) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    inc_c = 1'b0;
                end
            end
            if (dec_b) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    dec_b = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Blanking looks at the slot about to be shown; the ones slot never blanks.
    always_comb begin
        unique case (next_idx)
            2'd1:    hi_zero = (count[15:4] == 12'd0);
            2'd2:    hi_zero = (count[15:8] == 8'd0);
            2'd3:    hi_zero = (count[15:12] == 4'd0);
            default: hi_zero = 1'b0;
        endcase
        blank = lzb && hi_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdiv  <= '0;
            count <= '0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                count <= '0;
                tdiv  <= '0;
            end else if (load) begin
                count <= load_clamped;
                tdiv  <= '0;
            end else begin
                if (en) begin
                    tdiv <= tick ? '0 : tdiv + TW'(1);
                end
                if (tick) begin
                    count <= up ? count_inc : count_dec;
                    carry <= up ? (count == 16'h9999) : (count == 16'h0000);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdiv      <= '0;
            idx       <= '0;
            shown     <= '0;
            digit_sel <= 4'b1110;
        end else if (scan_wrap) begin
            sdiv      <= '0;
            idx       <= next_idx;
            shown     <= count[{next_idx, 2'b00} +: 4];
            digit_sel <= blank ? '1 : ~(4'b0001 << next_idx);
        end else begin
            sdiv <= sdiv + SW'(1);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: an arithmetic reference model
// predicts every cycle's outputs; a monitor compares them against the DUT.
module tb_bcd_scan_counter;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;

    logic        clk = 1'b0;
    logic        rst, en, up, clr, load, lzb;
    logic [15:0] load_val;
    logic        a, b, c, d;
    logic [3:0]  digit_sel;
    logic [15:0] count;
    logic        carry;

    bcd_scan_counter #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .lzb(lzb),
        .a(a), .b(b), .c(c), .d(d),
        .digit_sel(digit_sel), .count(count), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] count;
        logic        carry;
        logic [3:0]  sel;
        logic [3:0]  abcd;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Stimulus values applied by step()
    logic        s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_clr = 1'b0, s_load = 1'b0, s_lzb = 1'b0;
    logic [15:0] s_lv = '0;

    // Reference model state: decimal value and plain integer counters
    int m_val = 0, m_tc = 0, m_sc = 0, m_idx = 0;
    logic [3:0] m_sel = 4'b1110, m_abcd = 4'd0;
    logic       m_carry = 1'b0;
    int pow10[4] = '{1, 10, 100, 1000};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            int n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v += n * pow10[i];
        end
        return v;
    endfunction

    task automatic model_step();
        int old;
        bit tk;
        if (s_rst) begin
            m_val = 0; m_tc = 0; m_sc = 0; m_idx = 0;
            m_sel = 4'b1110; m_abcd = 4'd0; m_carry = 1'b0;
        end else begin
            old = m_val;
            tk = s_en && (m_tc == TICK_DIV - 1);
            m_carry = 1'b0;
            if (s_clr) begin
                m_val = 0; m_tc = 0;
            end else if (s_load) begin
                m_val = clamp_val(s_lv); m_tc = 0;
            end else begin
                if (s_en) m_tc = tk ? 0 : m_tc + 1;
                if (tk) begin
                    if (s_up) begin
                        m_carry = (m_val == 9999);
                        m_val = (m_val + 1) % 10000;
                    end else begin
                        m_carry = (m_val == 0);
                        m_val = (m_val + 9999) % 10000;
                    end
                end
            end
            if (m_sc == SCAN_DIV - 1) begin
                m_sc = 0;
                m_idx = (m_idx + 1) % 4;
                m_abcd = 4'((old / pow10[m_idx]) % 10);
                if (s_lzb && m_idx != 0 && (old / pow10[m_idx]) == 0) m_sel = 4'b1111;
                else m_sel = ~(4'b0001 << m_idx);
            end else begin
                m_sc = m_sc + 1;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        rst = s_rst; en = s_en; up = s_up; clr = s_clr; load = s_load;
        load_val = s_lv; lzb = s_lzb;
        model_step();
        e.count = to_bcd(m_val);
        e.carry = m_carry;
        e.sel   = m_sel;
        e.abcd  = m_abcd;
        q.push_back(e);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        s_load = 1'b1; s_lv = v;
        step();
        s_load = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count", count, e.count);
                check("carry", 16'(carry), 16'(e.carry));
                check("digit_sel", 16'(digit_sel), 16'(e.sel));
                check("abcd", 16'({a, b, c, d}), 16'(e.abcd));
            end
        end
    end

    initial begin : stimulus
        int r;
        rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; lzb = 1'b0;

        // Reset, then free counting from 0000
        s_rst = 1'b1; steps(3);
        s_rst = 1'b0; s_en = 1'b1; s_up = 1'b1; steps(10);

        // Up wrap 9998 -> 9999 -> 0000
        do_load(16'h9998); steps(12);

        // Down borrow 1000 -> 0999, then 0000 -> 9999
        s_up = 1'b0; do_load(16'h1000); steps(6);
        do_load(16'h0000); steps(6);

        // Clamp, clr-over-load priority, enable hold
        s_up = 1'b1; do_load(16'hA5F3); steps(2);
        s_clr = 1'b1; s_load = 1'b1; s_lv = 16'h1234; step();
        s_clr = 1'b0; s_load = 1'b0;
        do_load(16'h0777); s_en = 1'b0; steps(20); s_en = 1'b1;

        // Scan order with a stable value
        s_en = 1'b0; s_lzb = 1'b0; do_load(16'h1234); steps(15);

        // Leading-zero blanking, including an interior zero
        s_lzb = 1'b1; do_load(16'h0042); steps(15);
        do_load(16'h0000); steps(15);
        do_load(16'h0105); steps(15);

        // Load together with a tick: the load wins
        s_en = 1'b1; s_lzb = 1'b0; do_load(16'h0500); steps(3);
        do_load(16'h0321); steps(4);

        // Mid-scan reset
        steps(2); s_rst = 1'b1; step(); s_rst = 1'b0; steps(8);

        // Randomized operation
        for (int i = 0; i < 600; i++) begin
            s_rst  = ($urandom_range(0, 99) == 0);
            s_clr  = ($urandom_range(0, 49) == 0);
            s_load = ($urandom_range(0, 19) == 0);
            s_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) s_up = ~s_up;
            if ($urandom_range(0, 31) == 0) s_lzb = ~s_lzb;
            r = $urandom_range(0, 4);
            case (r)
                0: s_lv = 16'h9999;
                1: s_lv = 16'h0000;
                2: s_lv = 16'h0001;
                3: s_lv = 16'h9998;
                default: s_lv = 16'($urandom);
            endcase
            step();
        end
        s_rst = 1'b0; s_clr = 1'b0; s_load = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
